// File: rtl/mux_rr_sequencer_if.sv
// Request/grant bus between the requesters and the shared-lane sequencer.
// The slave side is the sequencer. The master side is whatever drives the requests and mux data.
interface mux_rr_sequencer_if #(
  parameter int N    = 16,
  parameter int SELW = 4
);
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    D;
  logic [SELW-1:0] sel;
  logic [N-1:0]    grant;
  logic            gnt_vld;
  logic            M;
  logic            timeout;

  modport slave (
    input  req, done, D,
    output sel, grant, gnt_vld, M, timeout
  );

  modport master (
    output req, done, D,
    input  sel, grant, gnt_vld, M, timeout
  );
endinterface

// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer for a shared select mux.
// It grants one requester at a time and holds that grant until one of three things happens:
//   - the owner signals done,
//   - the owner drops its request, or
//   - the hold limit expires.
// It is the only driver of the mux select.
module mux_rr_sequencer #(
  parameter int N        = 16,
  parameter int SELW     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_rr_sequencer_if.slave    bus
);
  localparam int W   = 2 ** SELW;
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [SELW-1:0] sel_reg, sel_next;
  logic [SELW-1:0] ptr_reg, ptr_next;
  logic [N-1:0]    grant_reg, grant_next;
  logic [HCW-1:0]  hold_cnt_reg, hold_cnt_next;
  logic            timeout_reg, timeout_next;

  // Requests and data padded to the full select range.
  // Indices >= N then read as zero and can never win arbitration.
  logic [W-1:0] req_ext;
  logic [W-1:0] d_ext;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_pad
      if (gi < N) begin : g_live
        assign req_ext[gi] = bus.req[gi];
        assign d_ext[gi]   = bus.D[gi];
      end else begin : g_dead
        assign req_ext[gi] = 1'b0;
        assign d_ext[gi]   = 1'b0;
      end
    end
  endgenerate

  // Rotating priority search.
  // It takes the first set request scanning from ptr upward and wraps at N-1.
  logic            found;
  logic [SELW-1:0] winner;
  int              idx;
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_ext[idx[SELW-1:0]]) begin
        found  = 1'b1;
        winner = idx[SELW-1:0];
      end
    end
  end

  // Release causes for the current owner.
  logic owner_req;
  logic hit_max;
  logic release_now;
  assign owner_req   = req_ext[sel_reg];
  assign hit_max     = (MAX_HOLD != 0) && (hold_cnt_reg == HCW'(MAX_HOLD - 1));
  assign release_now = bus.done || !owner_req || hit_max;

  // Next-state and next-output logic for the IDLE/GRANT sequencer.
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    ptr_next      = ptr_reg;
    grant_next    = grant_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next    = GRANT;
          sel_next      = winner;
          grant_next    = {{(N-1){1'b0}}, 1'b1} << winner;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        hold_cnt_next = hold_cnt_reg + 1'b1;
        if (release_now) begin
          state_next   = IDLE;
          grant_next   = '0;
          ptr_next     = (sel_reg == SELW'(N - 1)) ? '0 : sel_reg + 1'b1;
          // A forced release is reported only when it is the sole cause.
          // If done or a dropped request coincides with it, the release counts as normal.
          timeout_next = hit_max && !bus.done && owner_req;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers.
  // The asynchronous reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      ptr_reg      <= ptr_next;
      grant_reg    <= grant_next;
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign bus.sel     = sel_reg;
  assign bus.grant   = grant_reg;
  assign bus.gnt_vld = (state_reg == GRANT);
  assign bus.timeout = timeout_reg;
  assign bus.M       = (state_reg == GRANT) && d_ext[sel_reg];
endmodule
